// File: rtl/gpr_file_mp.sv
// gpr_file_mp: multi-port general-purpose register file with a per-register
// busy scoreboard. Read ports are combinational with an optional same-cycle
// write bypass. Register 0 can be hardwired to zero. Out-of-range addresses
// read as 0 and are never written or marked busy.
module gpr_file_mp #(
    parameter int DATA_WIDTH  = 32,
    parameter int REG_NUM     = 32,
    parameter int REG_NUM_BIT = 5,
    parameter int NUM_RD      = 2,
    parameter int NUM_WR      = 1,
    parameter int BYPASS      = 1,
    parameter int ZERO_REG    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_RD*REG_NUM_BIT-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]  rd_data,
    output logic [NUM_RD-1:0]             rd_busy,
    input  logic [NUM_WR-1:0]             wr_en,
    input  logic [NUM_WR*REG_NUM_BIT-1:0] wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0]  wr_data,
    input  logic                          issue_en,
    input  logic [REG_NUM_BIT-1:0]        issue_addr,
    input  logic                          flush,
    input  logic [REG_NUM_BIT-1:0]        dbg_addr,
    output logic [DATA_WIDTH-1:0]         dbg_data
);

    logic [DATA_WIDTH-1:0] rf_q [REG_NUM];
    logic [DATA_WIDTH-1:0] rf_d [REG_NUM];
    logic [REG_NUM-1:0]    busy_q, busy_d;

    // An address is writable/issuable when it exists and is not the hardwired zero register.
    function automatic logic in_rng(input logic [REG_NUM_BIT-1:0] a);
        return int'(a) < REG_NUM;
    endfunction

    function automatic logic is_zero(input logic [REG_NUM_BIT-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Next state: writes in ascending port order so the highest port wins;
    // a write clears busy, a same-cycle issue re-sets it (younger producer),
    // and flush clears everything last.
    always_comb begin
        rf_d   = rf_q;
        busy_d = busy_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && in_rng(wr_addr[w*REG_NUM_BIT +: REG_NUM_BIT])
                && !is_zero(wr_addr[w*REG_NUM_BIT +: REG_NUM_BIT])) begin
                rf_d[wr_addr[w*REG_NUM_BIT +: REG_NUM_BIT]]   = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
                busy_d[wr_addr[w*REG_NUM_BIT +: REG_NUM_BIT]] = 1'b0;
            end
        end
        if (issue_en && in_rng(issue_addr) && !is_zero(issue_addr)) begin
            busy_d[issue_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    // State registers; async reset overrides any same-cycle update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_q   <= '{default: '0};
            busy_q <= '0;
        end else begin
            rf_q   <= rf_d;
            busy_q <= busy_d;
        end
    end

    // Read ports: stored value, optionally overridden by the highest enabled
    // same-cycle write; busy always comes from registered state.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            logic [REG_NUM_BIT-1:0] a;
            logic [DATA_WIDTH-1:0]  v;
            a = rd_addr[r*REG_NUM_BIT +: REG_NUM_BIT];
            v = '0;
            if (in_rng(a)) begin
                v          = rf_q[a];
                rd_busy[r] = busy_q[a];
                if (BYPASS != 0) begin
                    for (int w = 0; w < NUM_WR; w++) begin
                        if (wr_en[w] && wr_addr[w*REG_NUM_BIT +: REG_NUM_BIT] == a) begin
                            v = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
                if (is_zero(a)) begin
                    v = '0;
                end
            end
            rd_data[r*DATA_WIDTH +: DATA_WIDTH] = v;
        end
    end

    // Debug port shows the stored value only.
    always_comb begin
        dbg_data = '0;
        if (in_rng(dbg_addr)) begin
            dbg_data = rf_q[dbg_addr];
        end
    end

endmodule

// File: tb/tb_gpr_file_mp.sv
// Directed bench for gpr_file_mp. Two instances share all stimulus:
//   A: 32 regs, 2 write ports, bypass on,  zero reg on
//   B: 24 regs, 2 write ports, bypass off, zero reg off
module tb_gpr_file_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic [1:0]  wr_en = '0;
    logic [9:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        issue_en = 1'b0;
    logic [4:0]  issue_addr = '0;
    logic        flush = 1'b0;
    logic [4:0]  dbg_addr = '0;

    logic [63:0] a_rd_data, b_rd_data;
    logic [1:0]  a_rd_busy, b_rd_busy;
    logic [31:0] a_dbg, b_dbg;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    gpr_file_mp #(.DATA_WIDTH(32), .REG_NUM(32), .REG_NUM_BIT(5), .NUM_RD(2), .NUM_WR(2),
                  .BYPASS(1), .ZERO_REG(1)) u_a (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
        .issue_addr(issue_addr), .flush(flush), .dbg_addr(dbg_addr), .dbg_data(a_dbg));

    gpr_file_mp #(.DATA_WIDTH(32), .REG_NUM(24), .REG_NUM_BIT(5), .NUM_RD(2), .NUM_WR(2),
                  .BYPASS(0), .ZERO_REG(0)) u_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
        .issue_addr(issue_addr), .flush(flush), .dbg_addr(dbg_addr), .dbg_data(b_dbg));

    task automatic idle();
        wr_en = '0; issue_en = 1'b0; flush = 1'b0;
    endtask

    // Advance past one posedge, drop the one-cycle controls, let outputs settle.
    task automatic step();
        @(posedge clk); #1;
        idle();
        #1;
    endtask

    task automatic wr(input int p, input logic [4:0] ad, input logic [31:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*5 +: 5] = ad;
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic test_reset();
        rd_addr = {5'd8, 5'd5};
        #3;
        total++; if (a_rd_data !== 64'h0) begin bad++; $display("FAIL reset_a_rd got %h exp 0", a_rd_data); end
        total++; if ((a_rd_busy | b_rd_busy) !== 2'b00) begin bad++; $display("FAIL reset_busy got %b/%b exp 00", a_rd_busy, b_rd_busy); end
        @(negedge clk); rst_n = 1'b1;
        wr(0, 5'd5, 32'hDEAD); issue_en = 1'b1; issue_addr = 5'd8; dbg_addr = 5'd5;
        step();
        total++; if (a_dbg !== 32'hDEAD) begin bad++; $display("FAIL pre_reset_dbg got %h exp dead", a_dbg); end
        total++; if (b_rd_busy !== 2'b10) begin bad++; $display("FAIL pre_reset_busy got %b exp 10", b_rd_busy); end
        rst_n = 1'b0;           // mid-cycle, no clock edge
        #1;
        total++; if (a_dbg !== 32'h0 || b_dbg !== 32'h0) begin bad++; $display("FAIL async_reset_dbg got %h/%h exp 0", a_dbg, b_dbg); end
        total++; if (a_rd_data[31:0] !== 32'h0) begin bad++; $display("FAIL async_reset_rd got %h exp 0", a_rd_data[31:0]); end
        total++; if ((a_rd_busy | b_rd_busy) !== 2'b00) begin bad++; $display("FAIL async_reset_busy got %b/%b exp 00", a_rd_busy, b_rd_busy); end
        #1; rst_n = 1'b1;
    endtask

    task automatic test_bypass();
        rd_addr = {5'd0, 5'd3};
        wr(0, 5'd3, 32'h1234);
        #1;
        total++; if (a_rd_data[31:0] !== 32'h1234) begin bad++; $display("FAIL bypass_a got %h exp 1234", a_rd_data[31:0]); end
        total++; if (b_rd_data[31:0] !== 32'h0) begin bad++; $display("FAIL nobypass_b_before got %h exp 0", b_rd_data[31:0]); end
        step();
        total++; if (b_rd_data[31:0] !== 32'h1234) begin bad++; $display("FAIL nobypass_b_after got %h exp 1234", b_rd_data[31:0]); end
        total++; if (a_rd_data[31:0] !== 32'h1234) begin bad++; $display("FAIL bypass_a_after got %h exp 1234", a_rd_data[31:0]); end
    endtask

    task automatic test_zero_reg();
        rd_addr = {5'd0, 5'd0};
        wr(0, 5'd0, 32'hFFFF_FFFF); issue_en = 1'b1; issue_addr = 5'd0;
        #1;
        total++; if (a_rd_data[31:0] !== 32'h0) begin bad++; $display("FAIL zero_bypass_a got %h exp 0", a_rd_data[31:0]); end
        step();
        total++; if (a_rd_data !== 64'h0) begin bad++; $display("FAIL zero_a_rd got %h exp 0", a_rd_data); end
        total++; if (a_rd_busy !== 2'b00) begin bad++; $display("FAIL zero_a_busy got %b exp 00", a_rd_busy); end
        total++; if (b_rd_data[31:0] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL nozero_b_rd got %h exp ffffffff", b_rd_data[31:0]); end
        total++; if (b_rd_busy !== 2'b11) begin bad++; $display("FAIL nozero_b_busy got %b exp 11", b_rd_busy); end
    endtask

    task automatic test_conflict();
        rd_addr = {5'd7, 5'd0};
        wr(0, 5'd7, 32'hA); wr(1, 5'd7, 32'hB); dbg_addr = 5'd7;
        #1;
        total++; if (a_rd_data[63:32] !== 32'hB) begin bad++; $display("FAIL conflict_bypass got %h exp b", a_rd_data[63:32]); end
        step();
        total++; if (a_dbg !== 32'hB || b_dbg !== 32'hB) begin bad++; $display("FAIL conflict_store got %h/%h exp b", a_dbg, b_dbg); end
    endtask

    task automatic test_scoreboard();
        rd_addr = {5'd0, 5'd9}; dbg_addr = 5'd9;
        issue_en = 1'b1; issue_addr = 5'd9;
        #1;
        total++; if (a_rd_busy[0] !== 1'b0) begin bad++; $display("FAIL issue_not_bypassed got %b exp 0", a_rd_busy[0]); end
        step();
        total++; if (a_rd_busy[0] !== 1'b1 || b_rd_busy[0] !== 1'b1) begin bad++; $display("FAIL issue_busy got %b/%b exp 1", a_rd_busy[0], b_rd_busy[0]); end
        wr(1, 5'd9, 32'h99);
        step();
        total++; if (a_rd_busy[0] !== 1'b0 || b_rd_busy[0] !== 1'b0) begin bad++; $display("FAIL write_clears got %b/%b exp 0", a_rd_busy[0], b_rd_busy[0]); end
        wr(0, 5'd9, 32'h77); issue_en = 1'b1; issue_addr = 5'd9;
        step();
        total++; if (a_rd_busy[0] !== 1'b1 || b_rd_busy[0] !== 1'b1) begin bad++; $display("FAIL issue_wins got %b/%b exp 1", a_rd_busy[0], b_rd_busy[0]); end
        total++; if (a_dbg !== 32'h77) begin bad++; $display("FAIL issue_write_data got %h exp 77", a_dbg); end
    endtask

    task automatic test_flush();
        issue_en = 1'b1; issue_addr = 5'd2; step();
        issue_en = 1'b1; issue_addr = 5'd4; step();
        rd_addr = {5'd4, 5'd2};
        #1;
        total++; if (a_rd_busy !== 2'b11) begin bad++; $display("FAIL flush_pre_busy got %b exp 11", a_rd_busy); end
        flush = 1'b1; issue_en = 1'b1; issue_addr = 5'd6; wr(0, 5'd4, 32'h55); dbg_addr = 5'd4;
        step();
        total++; if (a_rd_busy !== 2'b00 || b_rd_busy !== 2'b00) begin bad++; $display("FAIL flush_busy got %b/%b exp 00", a_rd_busy, b_rd_busy); end
        total++; if (a_dbg !== 32'h55 || b_dbg !== 32'h55) begin bad++; $display("FAIL flush_write got %h/%h exp 55", a_dbg, b_dbg); end
        rd_addr = {5'd9, 5'd6};
        #1;
        total++; if (a_rd_busy !== 2'b00) begin bad++; $display("FAIL flush_issue_9 got %b exp 00", a_rd_busy); end
    endtask

    task automatic test_range();
        rd_addr = {5'd0, 5'd25}; dbg_addr = 5'd25;
        wr(0, 5'd25, 32'hCAFE); issue_en = 1'b1; issue_addr = 5'd25;
        step();
        total++; if (b_rd_data[31:0] !== 32'h0 || b_dbg !== 32'h0) begin bad++; $display("FAIL range_b_data got %h/%h exp 0", b_rd_data[31:0], b_dbg); end
        total++; if (b_rd_busy[0] !== 1'b0) begin bad++; $display("FAIL range_b_busy got %b exp 0", b_rd_busy[0]); end
        total++; if (a_dbg !== 32'hCAFE || a_rd_busy[0] !== 1'b1) begin bad++; $display("FAIL range_a got %h/%b exp cafe/1", a_dbg, a_rd_busy[0]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_b;
        rd_addr = {5'd0, 5'd10};
        exp_b = 32'h0;
        for (int k = 1; k <= 3; k++) begin
            wr(k % 2, 5'd10, 32'(k));
            #1;
            total++; if (a_rd_data[31:0] !== 32'(k)) begin bad++; $display("FAIL b2b_a_%0d got %h exp %h", k, a_rd_data[31:0], k); end
            total++; if (b_rd_data[31:0] !== exp_b) begin bad++; $display("FAIL b2b_b_%0d got %h exp %h", k, b_rd_data[31:0], exp_b); end
            step();
            exp_b = 32'(k);
        end
        total++; if (a_rd_data[31:0] !== 32'h3 || b_rd_data[31:0] !== 32'h3) begin bad++; $display("FAIL b2b_final got %h/%h exp 3", a_rd_data[31:0], b_rd_data[31:0]); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_zero_reg();
        test_conflict();
        test_scoreboard();
        test_flush();
        test_range();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
